// File: rtl/custom_wb_stage_if.sv
// Bundle for the writeback stage: execute-side input, core commit/kill decisions,
// and the committed-result return path to the core.
interface custom_wb_stage_if #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 4
);
  logic                         ex_valid_i;
  logic [ID_WIDTH-1:0]          ex_id_i;
  logic [31:0]                  ex_rd_i;
  logic [4:0]                   ex_rd_addr_i;
  logic                         ex_we_i;
  logic                         ex_ready_o;

  logic                         commit_valid_i;
  logic [ID_WIDTH-1:0]          commit_id_i;
  logic                         commit_kill_i;

  logic                         result_valid_o;
  logic                         result_ready_i;
  logic [ID_WIDTH-1:0]          result_id_o;
  logic [31:0]                  result_data_o;
  logic [4:0]                   result_rd_o;
  logic                         result_we_o;
  logic [$clog2(DEPTH+1)-1:0]   occupancy_o;

  modport master (
    output ex_valid_i, ex_id_i, ex_rd_i, ex_rd_addr_i, ex_we_i,
    output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  ex_ready_o, result_valid_o, result_id_o, result_data_o,
    input  result_rd_o, result_we_o, occupancy_o
  );

  modport slave (
    input  ex_valid_i, ex_id_i, ex_rd_i, ex_rd_addr_i, ex_we_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output ex_ready_o, result_valid_o, result_id_o, result_data_o,
    output result_rd_o, result_we_o, occupancy_o
  );
endinterface

// File: rtl/custom_wb_stage.sv
// Writeback stage: in-order result FIFO gated by a per-id commit/kill table.
// Only committed heads are returned to the core; killed heads are dropped silently.
module custom_wb_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  custom_wb_stage_if.slave bus
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned NID = 1 << ID_WIDTH;

  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [31:0]         data_q [DEPTH];
  logic [4:0]          rd_q   [DEPTH];
  logic [DEPTH-1:0]    we_q;

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [NID-1:0]      seen_q, seen_d;
  logic [NID-1:0]      kill_q, kill_d;

  logic                push, pop;
  logic                head_present, head_seen, head_kill;
  logic [ID_WIDTH-1:0] head_id;

  always_comb begin
    head_id      = id_q[rd_ptr_q];
    head_present = (count_q != '0);
    head_seen    = seen_q[head_id];
    head_kill    = kill_q[head_id];

    // Full blocks input even while the head pops: no same-cycle bypass of the full flag.
    push = bus.ex_valid_i && (count_q < CW'(DEPTH));
    pop  = head_present && head_seen && (head_kill || bus.result_ready_i);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

    seen_d = seen_q;
    kill_d = kill_q;
    if (pop) begin
      seen_d[head_id] = 1'b0;
      kill_d[head_id] = 1'b0;
    end
    // A same-cycle decision targets a reused id, so it overrides the pop clear.
    if (bus.commit_valid_i) begin
      seen_d[bus.commit_id_i] = 1'b1;
      kill_d[bus.commit_id_i] = bus.commit_kill_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seen_q   <= '0;
      kill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seen_q   <= seen_d;
      kill_q   <= kill_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
      we_q <= '0;
    end else if (push) begin
      id_q[wr_ptr_q]   <= bus.ex_id_i;
      data_q[wr_ptr_q] <= bus.ex_rd_i;
      rd_q[wr_ptr_q]   <= bus.ex_rd_addr_i;
      we_q[wr_ptr_q]   <= bus.ex_we_i;
    end
  end

  assign bus.ex_ready_o     = (count_q < CW'(DEPTH));
  assign bus.result_valid_o = head_present && head_seen && !head_kill;
  assign bus.result_id_o    = head_id;
  assign bus.result_data_o  = data_q[rd_ptr_q];
  assign bus.result_rd_o    = rd_q[rd_ptr_q];
  assign bus.result_we_o    = we_q[rd_ptr_q];
  assign bus.occupancy_o    = count_q;

endmodule
